// File: rtl/pwm_multich_generator_pkg.sv
// Shared types, board mode table and saturating duty arithmetic for the
// multi-channel PWM generator.
package pwm_multich_generator_pkg;

  // Width used internally by sat_add; callers zero-extend into it.
  localparam int SAT_W = 16;

  typedef enum logic [1:0] {
    MODE_10M = 2'd0,
    MODE_5M  = 2'd1,
    MODE_1M  = 2'd2
  } mode_e;

  // Divider and adjust steps per output rate, from a 100 MHz clk.
  localparam logic [7:0] DIV_10M         = 8'd10;
  localparam logic [7:0] STEP_COARSE_10M = 8'd2;
  localparam logic [7:0] STEP_FINE_10M   = 8'd1;
  localparam logic [7:0] DIV_5M          = 8'd20;
  localparam logic [7:0] STEP_COARSE_5M  = 8'd4;
  localparam logic [7:0] STEP_FINE_5M    = 8'd1;
  localparam logic [7:0] DIV_1M          = 8'd100;
  localparam logic [7:0] STEP_COARSE_1M  = 8'd10;
  localparam logic [7:0] STEP_FINE_1M    = 8'd1;

  function automatic logic [7:0] mode_div(input mode_e mode);
    case (mode)
      MODE_5M: return DIV_5M;
      MODE_1M: return DIV_1M;
      default: return DIV_10M;
    endcase
  endfunction

  function automatic logic [7:0] mode_step_coarse(input mode_e mode);
    case (mode)
      MODE_5M: return STEP_COARSE_5M;
      MODE_1M: return STEP_COARSE_1M;
      default: return STEP_COARSE_10M;
    endcase
  endfunction

  function automatic logic [7:0] mode_step_fine(input mode_e mode);
    case (mode)
      MODE_5M: return STEP_FINE_5M;
      MODE_1M: return STEP_FINE_1M;
      default: return STEP_FINE_10M;
    endcase
  endfunction

  // a +/- step with one extra bit of headroom, clamped to [0, max].
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] step,
                                                input logic             inc,
                                                input logic [SAT_W-1:0] max);
    logic [SAT_W:0] res;
    if (inc)
      res = {1'b0, a} + {1'b0, step};
    else if (a < step)
      res = '0;
    else
      res = {1'b0, a} - {1'b0, step};
    if (res > {1'b0, max})
      res = {1'b0, max};
    return res[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_multich_generator_channel.sv
// One PWM channel: working duty adjusted at runtime, shadow duty reloaded
// only at the period wrap so the output never produces runt pulses.
module pwm_multich_generator_channel
  import pwm_multich_generator_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] off,
  input  logic [W-1:0] per_sh,
  input  logic [W-1:0] per_next,
  input  logic         wrap,
  input  logic         sel,
  input  logic         inc_coarse,
  input  logic         dec_coarse,
  input  logic         inc_fine,
  input  logic         dec_fine,
  input  logic [W-1:0] step_coarse,
  input  logic [W-1:0] step_fine,
  input  logic [W-1:0] duty_nominal,
  output logic         pwm,
  output logic [W-1:0] duty_wk
);

  logic [W-1:0] duty_sh;
  logic [W-1:0] duty_next;
  logic [W-1:0] duty_init;
  logic [W-1:0] duty_load;
  logic [W-1:0] cnt_i;
  logic [W:0]   cnt_sum;

  // Reset/reload values are bounded by the period that is about to start.
  assign duty_init = (duty_nominal > per_next) ? per_next : duty_nominal;
  assign duty_load = (duty_wk > per_next) ? per_next : duty_wk;

  // Phase-shifted count; off < per_sh so one subtract suffices.
  assign cnt_sum = {1'b0, cnt} + {1'b0, off};
  assign cnt_i   = (cnt_sum >= {1'b0, per_sh}) ? W'(cnt_sum - {1'b0, per_sh})
                                               : cnt_sum[W-1:0];

  // Adjust: coarse pair wins; a cancelling pair falls through to the fine pair.
  always_comb begin
    duty_next = duty_wk;
    if (sel) begin
      if (inc_coarse ^ dec_coarse)
        duty_next = W'(sat_add(SAT_W'(duty_wk), SAT_W'(step_coarse),
                               inc_coarse, SAT_W'(per_sh)));
      else if (inc_fine ^ dec_fine)
        duty_next = W'(sat_add(SAT_W'(duty_wk), SAT_W'(step_fine),
                               inc_fine, SAT_W'(per_sh)));
    end
  end

  // Duty registers and registered PWM compare.
  always_ff @(posedge clk) begin
    if (srst) begin
      duty_wk <= duty_init;
      duty_sh <= duty_init;
      pwm     <= 1'b0;
    end else begin
      duty_wk <= duty_next;
      if (wrap)
        duty_sh <= duty_load;
      pwm <= (cnt_i < duty_sh);
    end
  end

endmodule

// File: rtl/pwm_multich_generator.sv
// N-channel PWM generator sharing one period counter, with optional
// per-channel phase stagger and period-boundary duty/period updates.
module pwm_multich_generator
  import pwm_multich_generator_pkg::*;
#(
  parameter int W    = 8,
  parameter int N_CH = 4
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic [W-1:0]            div_value,
  input  logic [W-1:0]            duty_nominal,
  input  logic [W-1:0]            step_coarse,
  input  logic [W-1:0]            step_fine,
  input  logic [$clog2(N_CH)-1:0] ch_sel,
  input  logic                    inc_coarse,
  input  logic                    dec_coarse,
  input  logic                    inc_fine,
  input  logic                    dec_fine,
  input  logic                    phase_en,
  output logic [N_CH-1:0]         pwm,
  output logic                    period_start,
  output logic [W-1:0]            duty_rd
);

  localparam int SEL_W = $clog2(N_CH);

  logic [W-1:0] cnt;
  logic [W-1:0] per_sh;
  logic [W-1:0] per_next;
  logic [W-1:0] seg;
  logic         ph_sh;
  logic         wrap;
  logic [W-1:0] duty_wk [N_CH];

  assign per_next = (div_value < W'(2)) ? W'(2) : div_value;
  assign wrap     = (cnt == per_sh - W'(1));
  assign seg      = per_sh >> SEL_W;

  // Period counter; period and phase mode are only taken at the wrap.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt    <= '0;
      per_sh <= per_next;
      ph_sh  <= phase_en;
    end else if (wrap) begin
      cnt    <= '0;
      per_sh <= per_next;
      ph_sh  <= phase_en;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] off;
    assign off = ph_sh ? W'(W'(i) * seg) : '0;

    pwm_multich_generator_channel #(.W(W)) u_ch (
      .clk          (clk),
      .srst         (srst),
      .cnt          (cnt),
      .off          (off),
      .per_sh       (per_sh),
      .per_next     (per_next),
      .wrap         (wrap),
      .sel          (ch_sel == SEL_W'(i)),
      .inc_coarse   (inc_coarse),
      .dec_coarse   (dec_coarse),
      .inc_fine     (inc_fine),
      .dec_fine     (dec_fine),
      .step_coarse  (step_coarse),
      .step_fine    (step_fine),
      .duty_nominal (duty_nominal),
      .pwm          (pwm[i]),
      .duty_wk      (duty_wk[i])
    );
  end

  // Period marker aligned with channel 0's edge, and duty readback.
  always_ff @(posedge clk) begin
    if (srst) begin
      period_start <= 1'b0;
      duty_rd      <= '0;
    end else begin
      period_start <= (cnt == '0);
      duty_rd      <= duty_wk[ch_sel];
    end
  end

endmodule

// File: tb/tb_pwm_multich_generator.sv
// Directed bench for pwm_multich_generator (W=8, N_CH=4).
module tb_pwm_multich_generator;

  logic       clk = 1'b0;
  logic       srst;
  logic [7:0] div_value;
  logic [7:0] duty_nominal;
  logic [7:0] step_coarse;
  logic [7:0] step_fine;
  logic [1:0] ch_sel;
  logic       inc_coarse;
  logic       dec_coarse;
  logic       inc_fine;
  logic       dec_fine;
  logic       phase_en;
  logic [3:0] pwm;
  logic       period_start;
  logic [7:0] duty_rd;

  int n_pass = 0;
  int n_chk  = 0;

  pwm_multich_generator #(.W(8), .N_CH(4)) dut (
    .clk          (clk),
    .srst         (srst),
    .div_value    (div_value),
    .duty_nominal (duty_nominal),
    .step_coarse  (step_coarse),
    .step_fine    (step_fine),
    .ch_sel       (ch_sel),
    .inc_coarse   (inc_coarse),
    .dec_coarse   (dec_coarse),
    .inc_fine     (inc_fine),
    .dec_fine     (dec_fine),
    .phase_en     (phase_en),
    .pwm          (pwm),
    .period_start (period_start),
    .duty_rd      (duty_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance until a period_start sample, at most 300 cycles.
  task automatic wait_ps(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_start && n < 300);
    check(tag, 32'(period_start), 32'd1);
  endtask

  task automatic pulse(input logic ic, input logic dc, input logic inf, input logic df);
    inc_coarse = ic; dec_coarse = dc; inc_fine = inf; dec_fine = df;
    tick();
    inc_coarse = 1'b0; dec_coarse = 1'b0; inc_fine = 1'b0; dec_fine = 1'b0;
    tick();
  endtask

  initial begin
    int len;
    logic [3:0] exp_pwm;

    srst = 1'b1; div_value = 8'd10; duty_nominal = 8'd5;
    step_coarse = 8'd1; step_fine = 8'd1; ch_sel = 2'd0;
    inc_coarse = 1'b0; dec_coarse = 1'b0; inc_fine = 1'b0; dec_fine = 1'b0;
    phase_en = 1'b0;

    // 1: reset state, then 5 high / 5 low in phase, period_start every 10
    tick(); tick();
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_ps", 32'(period_start), 32'd0);
    check("rst_duty_rd", 32'(duty_rd), 32'd0);
    srst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t1_pwm", 32'(pwm), ((k % 10) < 5) ? 32'hF : 32'h0);
      check("t1_ps", 32'(period_start), ((k % 10) == 0) ? 32'd1 : 32'd0);
    end
    check("t1_duty_rd", 32'(duty_rd), 32'd5);

    // 2: coarse inc on ch2 saturates at the period
    ch_sel = 2'd2;
    for (int j = 1; j <= 7; j++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check("t2_duty_rd", 32'(duty_rd), (5 + j > 10) ? 32'd10 : 32'(5 + j));
    end
    wait_ps("t2_sync");
    for (int k = 0; k < 10; k++) begin
      check("t2_pwm", 32'(pwm), (k < 5) ? 32'hF : 32'h4);
      tick();
    end

    // 3: fine dec on ch1 clamps at zero
    ch_sel = 2'd1; step_fine = 8'd2;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_duty_a", 32'(duty_rd), 32'd3);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_duty_b", 32'(duty_rd), 32'd1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_duty_c", 32'(duty_rd), 32'd0);
    wait_ps("t3_sync");
    for (int k = 0; k < 10; k++) begin
      check("t3_pwm", 32'(pwm), (k < 5) ? 32'hD : 32'h4);
      tick();
    end
    ch_sel = 2'd0; tick();
    check("t3_ch0", 32'(duty_rd), 32'd5);
    ch_sel = 2'd3; tick();
    check("t3_ch3", 32'(duty_rd), 32'd5);

    // 5: adjust priority, then period change mid-period
    ch_sel = 2'd0; step_coarse = 8'd1; step_fine = 8'd2;
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_pair_cancel_fine", 32'(duty_rd), 32'd7);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_coarse_prio", 32'(duty_rd), 32'd8);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_coarse_cancel", 32'(duty_rd), 32'd8);
    wait_ps("t5_sync");
    tick(); tick();
    len = 2;
    div_value = 8'd100;
    do begin
      tick();
      len++;
    end while (!period_start && len < 300);
    check("t5_len_old", 32'(len), 32'd10);
    check("t5_pwm_start", 32'(pwm), 32'hD);
    len = 0;
    do begin
      tick();
      len++;
    end while (!period_start && len < 300);
    check("t5_len_new", 32'(len), 32'd100);

    // 4: phase stagger, div=20, duty=10
    srst = 1'b1; div_value = 8'd20; duty_nominal = 8'd10; phase_en = 1'b1;
    tick();
    srst = 1'b0;
    wait_ps("t4_sync_a");
    wait_ps("t4_sync_b");
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++)
        exp_pwm[i] = (((k + 5 * i) % 20) < 10);
      check("t4_pwm", 32'(pwm), 32'(exp_pwm));
      tick();
    end

    // 6: reset mid-period while pwm[0] is high
    tick(); tick();
    check("t6_pre_high", 32'(pwm[0]), 32'd1);
    srst = 1'b1; duty_nominal = 8'd7; phase_en = 1'b0;
    tick();
    check("t6_rst_pwm", 32'(pwm), 32'd0);
    check("t6_rst_ps", 32'(period_start), 32'd0);
    check("t6_rst_duty_rd", 32'(duty_rd), 32'd0);
    srst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t6_pwm", 32'(pwm), (k < 7) ? 32'hF : 32'h0);
      check("t6_ps", 32'(period_start), (k == 0) ? 32'd1 : 32'd0);
    end
    check("t6_duty_rd", 32'(duty_rd), 32'd7);

    // div below 2 is treated as 2; nominal clamped to that period
    srst = 1'b1; div_value = 8'd1; duty_nominal = 8'd5;
    tick();
    srst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("tmin_pwm", 32'(pwm), 32'hF);
      check("tmin_ps", 32'(period_start), ((k % 2) == 0) ? 32'd1 : 32'd0);
    end
    check("tmin_duty_rd", 32'(duty_rd), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
